ifu_fetch: RTL and testbench

Instruction fetch unit sitting between the pipeline controller's jump/hold outputs and the instruction ROM bus. It owns the program counter and issues single-outstanding fetch requests over a req/gnt/rvalid handshake. It buffers returned words in a small FIFO and presents {instruction, address} to the IF/ID register. Jumps redirect the PC, flush the buffer and kill any in-flight response; hold stalls delivery while fetching continues until the buffer is full.

---
 rtl/ifu_fetch.sv | 153 +++++++++++++++
 tb/tb_ifu_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding ROM fetches and
// buffers returned words in a small FIFO feeding the IF/ID register.
module ifu_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } entry_t;

    state_e        state_q, state_d;
    logic          kill_q, kill_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    entry_t        buf_q [DEPTH];

    logic          req;
    logic [31:0]   addr;
    logic          push;
    logic          pop;
    logic          has_space;
    logic [CW:0]   occ;
    entry_t        head;

    // The outstanding fetch reserves a slot so its response always fits.
    always_comb begin
        occ       = {1'b0, count_q} + (CW+1)'(state_q == RSP);
        has_space = occ < (CW+1)'(DEPTH);
    end

    always_comb begin
        head         = buf_q[rd_ptr_q];
        inst_valid_o = (count_q != '0) && !jump_en_i;
        inst_o       = inst_valid_o ? head.inst : NOP_INST;
        inst_addr_o  = inst_valid_o ? head.addr : 32'h0;
        pop          = inst_valid_o && !hold_flag_i;
    end

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req        = 1'b0;
        addr       = pc_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_space && !jump_en_i) begin
                    req        = 1'b1;
                    req_addr_d = pc_q;
                    if (rom_gnt_i) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = RSP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Bus address comes from req_addr_q so a jump cannot disturb it.
                req  = 1'b1;
                addr = req_addr_q;
                if (jump_en_i) kill_d = 1'b1;
                if (rom_gnt_i) begin
                    state_d = RSP;
                    if (!kill_q) pc_d = req_addr_q + 32'd4;
                end
            end
            RSP: begin
                if (rom_rvalid_i) begin
                    push    = !kill_q && !jump_en_i;
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end else if (jump_en_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (jump_en_i) pc_d = jump_addr_i & 32'hFFFF_FFFC;
    end

    always_comb begin
        rom_req_o  = req && !rst;
        rom_addr_o = addr;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (jump_en_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            pc_q       <= RESET_ADDR;
            req_addr_q <= RESET_ADDR;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr_q] <= '{addr: req_addr_q, inst: rom_rdata_i};
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: ROM responder with programmable grant/response latency,
// scoreboard of expected {addr, inst} deliveries and directed timing checks.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] sb [$];

    int          gnt_dly = 0;
    int          rv_lat  = 1;
    bit          pend    = 1'b0;
    int          pcnt    = 0;
    int          wcnt    = 0;
    logic [31:0] paddr   = 32'h0;

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_load(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 40; i++)
            sb.push_back({start + 32'(4 * i), romf(start + 32'(4 * i))});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit need_vld, input string nm);
        int n;
        n = 0;
        while (!(rom_req_o && (!need_vld || inst_valid_o)) && n < 50) begin
            tick();
            n++;
        end
        chk(nm, 96'(n < 50), 96'd1);
    endtask

    // ROM: grants after gnt_dly waiting cycles, returns data rv_lat cycles later,
    // holds one transaction at a time.
    initial begin
        rom_gnt_i    = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            rom_rvalid_i = 1'b0;
            rom_rdata_i  = 32'hDEAD_BEEF;
            if (pend) begin
                if (pcnt <= 1) begin
                    rom_rvalid_i = 1'b1;
                    rom_rdata_i  = romf(paddr);
                    pend         = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            rom_gnt_i = 1'b0;
            if (rom_req_o && !pend) begin
                if (wcnt >= gnt_dly) begin
                    rom_gnt_i = 1'b1;
                    pend      = 1'b1;
                    pcnt      = rv_lat;
                    paddr     = rom_addr_o;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Monitor: every accepted head must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && inst_valid_o && !hold_flag_i && !jump_en_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL deliver: got %h/%h expected nothing", inst_addr_o, inst_o);
                end else begin
                    chk("deliver", 96'({inst_addr_o, inst_o}), 96'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        rst         = 1'b1;
        jump_en_i   = 1'b0;
        jump_addr_i = 32'h0;
        hold_flag_i = 1'b0;
        repeat (3) tick();

        chk("rst_req",   96'(rom_req_o),    96'd0);
        chk("rst_addr",  96'(rom_addr_o),   96'd0);
        chk("rst_valid", 96'(inst_valid_o), 96'd0);
        chk("rst_inst",  96'(inst_o),       96'h13);
        chk("rst_iaddr", 96'(inst_addr_o),  96'd0);

        // Zero-wait stream: first instruction two cycles after the first request.
        sb_load(32'h0);
        rst = 1'b0;
        #1;
        chk("first_req", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, 32'h0}));
        tick();
        chk("first_n1", 96'(inst_valid_o), 96'd0);
        tick();
        chk("first_n2", 96'({inst_valid_o, inst_addr_o, inst_o}), 96'({1'b1, 32'h0, romf(32'h0)}));
        repeat (12) tick();

        // Hold: buffer fills, fetching stops, release drains two back-to-back.
        hold_flag_i = 1'b1;
        repeat (10) tick();
        chk("hold_full", 96'({rom_req_o, inst_valid_o}), 96'({1'b0, 1'b1}));
        hold_flag_i = 1'b0;
        tick();
        chk("rel_n1", 96'({rom_req_o, inst_valid_o}), 96'({1'b1, 1'b1}));
        tick();
        chk("rel_n2", 96'(inst_valid_o), 96'd0);
        repeat (6) tick();

        // Jump while in RSP with the response still pending: it must be killed.
        rv_lat      = 2;
        hold_flag_i = 1'b1;
        wait_req(1'b1, "wait_b");
        tick();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0103;
        sb_load(32'h100);
        #1;
        chk("b_mask", 96'({inst_valid_o, rom_req_o}), 96'd0);
        tick();
        jump_en_i   = 1'b0;
        hold_flag_i = 1'b0;
        rv_lat      = 1;
        #1;
        chk("b_j1_noreq", 96'(rom_req_o), 96'd0);
        tick();
        chk("b_j2_req", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, 32'h100}));
        repeat (2) tick();
        chk("b_j4_valid", 96'({inst_valid_o, inst_addr_o}), 96'({1'b1, 32'h100}));
        repeat (6) tick();

        // Jump while waiting for a delayed grant: address stays, response dropped.
        gnt_dly = 3;
        wait_req(1'b0, "wait_c");
        a = rom_addr_o;
        tick();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0200;
        sb_load(32'h200);
        #1;
        chk("c_j_addr",  96'({rom_req_o, rom_addr_o}), 96'({1'b1, a}));
        chk("c_j_mask",  96'(inst_valid_o), 96'd0);
        tick();
        jump_en_i = 1'b0;
        #1;
        chk("c_j1_addr", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, a}));
        tick();
        chk("c_j2_addr", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, a}));
        tick();
        gnt_dly = 0;
        chk("c_j3_noreq", 96'(rom_req_o), 96'd0);
        tick();
        chk("c_j4_req", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, 32'h200}));
        repeat (2) tick();
        chk("c_j6_valid", 96'({inst_valid_o, inst_addr_o}), 96'({1'b1, 32'h200}));
        repeat (4) tick();

        // Unaligned jump near the top of memory; PC wraps to zero.
        hold_flag_i = 1'b1;
        repeat (8) tick();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'hFFFF_FFFE;
        sb_load(32'hFFFF_FFFC);
        #1;
        chk("d_mask", 96'(inst_valid_o), 96'd0);
        tick();
        jump_en_i = 1'b0;
        #1;
        chk("d_j1_req", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, 32'hFFFF_FFFC}));
        tick();
        chk("d_j2_noreq", 96'(rom_req_o), 96'd0);
        tick();
        hold_flag_i = 1'b0;
        #1;
        chk("d_wrap_req", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, 32'h0}));
        chk("d_j3_valid", 96'({inst_valid_o, inst_addr_o}), 96'({1'b1, 32'hFFFF_FFFC}));
        repeat (10) tick();

        // Reset while a slow response is outstanding; the late rvalid is ignored.
        rv_lat = 3;
        wait_req(1'b0, "wait_e");
        tick();
        rst    = 1'b1;
        rv_lat = 1;
        sb_load(32'h0);
        tick();
        chk("e_rst_out", 96'({rom_req_o, rom_addr_o, inst_valid_o, inst_o}),
            96'({1'b0, 32'h0, 1'b0, 32'h13}));
        chk("e_rst_iaddr", 96'(inst_addr_o), 96'd0);
        rst = 1'b0;
        #1;
        chk("e_req0", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, 32'h0}));
        tick();
        chk("e_req1", 96'({rom_req_o, rom_addr_o}), 96'({1'b1, 32'h0}));
        tick();
        chk("e_rsp", 96'(rom_req_o), 96'd0);
        tick();
        chk("e_valid", 96'({inst_valid_o, inst_addr_o, inst_o}), 96'({1'b1, 32'h0, romf(32'h0)}));
        repeat (10) tick();

        hold_flag_i = 1'b1;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
